// File: rtl/operand_forward_stage_pkg.sv
// Shared definitions for the ID->EX operand forwarding stage.
// - fwd_sel_e : operand source, FWD_NONE = register file, FWD_STGi = in-flight stage i (index+1)
// - fwd_tag_t : layout of one in-flight tag at the default widths
// - DEF_*     : default parameter values used by the top level
package operand_forward_stage_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_REG_AW   = 3;
  localparam int unsigned DEF_NUM_SRC  = 2;
  localparam int unsigned DEF_DEPTH    = 3;
  localparam int unsigned DEF_LOAD_LAT = 1;
  localparam int unsigned DEF_ZERO_REG = 1;

  localparam int unsigned DEF_SEL_W = $clog2(DEF_DEPTH + 1);

  typedef enum logic [DEF_SEL_W-1:0] {
    FWD_NONE = 2'd0,
    FWD_STG0 = 2'd1,
    FWD_STG1 = 2'd2,
    FWD_STG2 = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  is_load;
    logic [DEF_REG_AW-1:0] dst;
  } fwd_tag_t;

endpackage

// File: rtl/operand_forward_stage_fwd_select.sv
// Per-operand forwarding priority matcher (combinational).
// Inputs : src/src_used  - source register of one operand and whether it is read
//          tag_*         - in-flight tag fields, bit/slice i = stage i (0 = youngest)
// Outputs: sel           - winning source (FWD_NONE or stage index + 1)
//          load_pending  - winning stage holds a load whose data is not yet valid
module operand_forward_stage_fwd_select
  import operand_forward_stage_pkg::*;
#(
  parameter int unsigned REG_AW   = DEF_REG_AW,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG,
  parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic [REG_AW-1:0]       src,
  input  logic                    src_used,
  input  logic [DEPTH-1:0]        tag_valid,
  input  logic [DEPTH-1:0]        tag_wr,
  input  logic [DEPTH-1:0]        tag_load,
  input  logic [DEPTH*REG_AW-1:0] tag_dst,
  output logic [SEL_W-1:0]        sel,
  output logic                    load_pending
);

  logic src_ok;

  always_comb begin
    src_ok       = src_used && !((ZERO_REG != 0) && (src == '0));
    sel          = SEL_W'(FWD_NONE);
    load_pending = 1'b0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (src_ok && tag_valid[i] && tag_wr[i] && (tag_dst[i*REG_AW +: REG_AW] == src)) begin
        sel          = SEL_W'(i + 1);
        load_pending = tag_load[i] && (i < int'(LOAD_LAT));
      end
    end
  end

endmodule

// File: rtl/operand_forward_stage.sv
// ID->EX forwarding and operand-latch stage.
// Tracks DEPTH in-flight destination tags, resolves NUM_SRC operands per issuing instruction
// from the youngest matching in-flight result or the register file, stalls on load-use hazards
// and registers the resolved operands into EX.
// Ports: clk/rst_n (sync active-low); id_* issuing instruction and id_ready handshake;
//        fwd_val per-stage results; hold freezes everything; flush kills the ID instruction;
//        ex_valid/ex_opnd/ex_fwd_sel registered EX outputs; stall_cnt saturating stall count.
module operand_forward_stage
  import operand_forward_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned REG_AW   = DEF_REG_AW,
  parameter int unsigned NUM_SRC  = DEF_NUM_SRC,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG,
  parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0] id_reg_val,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_wr,
  input  logic                      id_is_load,
  input  logic [DEPTH*DATA_W-1:0]   fwd_val,
  input  logic                      hold,
  input  logic                      flush,
  output logic                      ex_valid,
  output logic [NUM_SRC*DATA_W-1:0] ex_opnd,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel,
  output logic [15:0]               stall_cnt
);

  // Tag pipeline, bit/slice i tracks the instruction whose result is on fwd_val[i].
  logic [DEPTH-1:0]        tag_valid_q;
  logic [DEPTH-1:0]        tag_wr_q;
  logic [DEPTH-1:0]        tag_load_q;
  logic [DEPTH*REG_AW-1:0] tag_dst_q;

  logic                      ex_valid_q;
  logic [NUM_SRC*DATA_W-1:0] ex_opnd_q;
  logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel_q;
  logic [15:0]               stall_cnt_q;

  logic [NUM_SRC*SEL_W-1:0]  sel_d;
  logic [NUM_SRC*DATA_W-1:0] opnd_d;
  logic [NUM_SRC-1:0]        pend;
  logic                      hazard;
  logic                      issue;
  logic                      stall_inc;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    operand_forward_stage_fwd_select #(
      .REG_AW   (REG_AW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .ZERO_REG (ZERO_REG),
      .SEL_W    (SEL_W)
    ) u_fwd_select (
      .src          (id_src[s*REG_AW +: REG_AW]),
      .src_used     (id_src_used[s]),
      .tag_valid    (tag_valid_q),
      .tag_wr       (tag_wr_q),
      .tag_load     (tag_load_q),
      .tag_dst      (tag_dst_q),
      .sel          (sel_d[s*SEL_W +: SEL_W]),
      .load_pending (pend[s])
    );
  end

  always_comb begin
    opnd_d = id_reg_val;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (sel_d[s*SEL_W +: SEL_W] == SEL_W'(i + 1)) begin
          opnd_d[s*DATA_W +: DATA_W] = fwd_val[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    hazard    = |pend;
    id_ready  = !hold && !hazard;
    issue     = id_valid && id_ready && !flush;
    stall_inc = id_valid && hazard && !flush && (stall_cnt_q != 16'hFFFF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_valid_q  <= '0;
      tag_wr_q     <= '0;
      tag_load_q   <= '0;
      tag_dst_q    <= '0;
      ex_valid_q   <= 1'b0;
      ex_opnd_q    <= '0;
      ex_fwd_sel_q <= {NUM_SRC{SEL_W'(FWD_NONE)}};
      stall_cnt_q  <= '0;
    end else if (!hold) begin
      // Non-issue cycles push a bubble; only the valid bit matters for a bubble.
      tag_valid_q <= {tag_valid_q[DEPTH-2:0], issue};
      tag_wr_q    <= {tag_wr_q[DEPTH-2:0], id_wr};
      tag_load_q  <= {tag_load_q[DEPTH-2:0], id_is_load};
      tag_dst_q   <= {tag_dst_q[(DEPTH-1)*REG_AW-1:0], id_dst};
      ex_valid_q  <= issue;
      if (issue) begin
        ex_opnd_q    <= opnd_d;
        ex_fwd_sel_q <= sel_d;
      end
      if (stall_inc) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_opnd    = ex_opnd_q;
  assign ex_fwd_sel = ex_fwd_sel_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_operand_forward_stage.sv
// Self-checking bench for operand_forward_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based behavioural model.
module tb_operand_forward_stage;

  localparam int DATA_W   = 8;
  localparam int REG_AW   = 3;
  localparam int NUM_SRC  = 2;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      id_valid;
  logic                      id_ready;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [NUM_SRC*DATA_W-1:0] id_reg_val;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_wr;
  logic                      id_is_load;
  logic [DEPTH*DATA_W-1:0]   fwd_val;
  logic                      hold;
  logic                      flush;
  logic                      ex_valid;
  logic [NUM_SRC*DATA_W-1:0] ex_opnd;
  logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel;
  logic [15:0]               stall_cnt;

  operand_forward_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_reg_val  (id_reg_val),
    .id_dst      (id_dst),
    .id_wr       (id_wr),
    .id_is_load  (id_is_load),
    .fwd_val     (fwd_val),
    .hold        (hold),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_opnd     (ex_opnd),
    .ex_fwd_sel  (ex_fwd_sel),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Model: history of what each advancing cycle pushed, index 0 = youngest in flight.
  typedef struct packed {
    bit       valid;
    bit       wr;
    bit       ld;
    bit [2:0] dst;
  } mtag_t;

  mtag_t hist[$];
  bit    m_ex_valid;
  int    m_opnd[NUM_SRC];
  int    m_sel[NUM_SRC];
  int    m_stall;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back('0);
    m_ex_valid = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      m_opnd[s] = 0;
      m_sel[s]  = 0;
    end
    m_stall = 0;
  endtask

  // One clock: compare at the negedge, advance the model, return just after the posedge.
  task automatic cyc();
    int  e_sel[NUM_SRC];
    int  e_op[NUM_SRC];
    bit  haz;
    bit  issue;
    int  src;
    mtag_t t;
    @(negedge clk);
    haz = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src     = int'(id_src[s*REG_AW +: REG_AW]);
      e_sel[s] = 0;
      e_op[s]  = int'(id_reg_val[s*DATA_W +: DATA_W]);
      if (id_src_used[s] && src != 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (hist[i].valid && hist[i].wr && int'(hist[i].dst) == src) begin
            e_sel[s] = i + 1;
            e_op[s]  = int'(fwd_val[i*DATA_W +: DATA_W]);
            if (i < LOAD_LAT && hist[i].ld) haz = 1'b1;
            break;
          end
        end
      end
    end
    chk("id_ready", 32'(id_ready), 32'(!hold && !haz));
    chk("ex_valid", 32'(ex_valid), 32'(m_ex_valid));
    if (m_ex_valid) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        chk($sformatf("ex_opnd[%0d]", s), 32'(ex_opnd[s*DATA_W +: DATA_W]), m_opnd[s]);
        chk($sformatf("ex_fwd_sel[%0d]", s), 32'(ex_fwd_sel[s*SEL_W +: SEL_W]), m_sel[s]);
      end
    end
    chk("stall_cnt", 32'(stall_cnt), m_stall);

    if (!rst_n) begin
      model_reset();
    end else if (!hold) begin
      issue   = id_valid && !haz && !flush;
      t.valid = issue;
      t.wr    = id_wr;
      t.ld    = id_is_load;
      t.dst   = id_dst;
      hist.push_front(t);
      void'(hist.pop_back());
      if (id_valid && haz && !flush && m_stall < 65535) m_stall++;
      m_ex_valid = issue;
      if (issue) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          m_opnd[s] = e_op[s];
          m_sel[s]  = e_sel[s];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input bit v, input int s0, input int s1, input bit [1:0] used,
                           input int rv0, input int rv1, input int dst, input bit wr,
                           input bit ld);
    id_valid    = v;
    id_src      = {3'(s1), 3'(s0)};
    id_src_used = used;
    id_reg_val  = {8'(rv1), 8'(rv0)};
    id_dst      = 3'(dst);
    id_wr       = wr;
    id_is_load  = ld;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    fwd_val = '0;
    set_instr(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cyc();
    rst_n = 1'b1;
    chk("reset ex_valid", 32'(ex_valid), 0);
    chk("reset ex_opnd", 32'(ex_opnd), 0);
    chk("reset ex_fwd_sel", 32'(ex_fwd_sel), 0);
    chk("reset stall_cnt", 32'(stall_cnt), 0);
    chk("reset id_ready", 32'(id_ready), 1);

    // No dependency: both operands from the register file.
    set_instr(1, 1, 2, 2'b11, 'h11, 'h22, 6, 1, 0);
    cyc();
    chk("nodep ex_opnd", 32'(ex_opnd), 32'h2211);
    chk("nodep sel", 32'(ex_fwd_sel), 0);

    // Back-to-back ALU dependency on r3.
    set_instr(1, 1, 2, 2'b11, 'h01, 'h02, 3, 1, 0);
    cyc();
    fwd_val = {8'h00, 8'h00, 8'h5A};
    set_instr(1, 3, 1, 2'b11, 'h99, 'h44, 7, 1, 0);
    cyc();
    chk("alu fwd opnd0", 32'(ex_opnd[7:0]), 32'h5A);
    chk("alu fwd sel0", 32'(ex_fwd_sel[1:0]), 1);
    chk("alu fwd opnd1", 32'(ex_opnd[15:8]), 32'h44);

    // Two in-flight writers of r4: the younger (stage 0) wins.
    set_instr(1, 0, 0, 2'b00, 0, 0, 4, 1, 0);
    cyc();
    cyc();
    fwd_val = {8'h00, 8'hBB, 8'hAA};
    set_instr(1, 4, 0, 2'b01, 'h12, 0, 7, 0, 0);
    cyc();
    chk("youngest opnd0", 32'(ex_opnd[7:0]), 32'hAA);
    chk("youngest sel0", 32'(ex_fwd_sel[1:0]), 1);

    // Load-use on r5: one bubble, then forward from stage 1.
    set_instr(1, 0, 0, 2'b00, 0, 0, 5, 1, 1);
    cyc();
    fwd_val = {8'h00, 8'h77, 8'h00};
    set_instr(1, 5, 0, 2'b01, 'h10, 0, 7, 0, 0);
    #1;
    chk("loaduse id_ready low", 32'(id_ready), 0);
    cyc();
    chk("loaduse bubble", 32'(ex_valid), 0);
    chk("loaduse stall_cnt", 32'(stall_cnt), 1);
    chk("loaduse id_ready high", 32'(id_ready), 1);
    cyc();
    chk("loaduse ex_valid", 32'(ex_valid), 1);
    chk("loaduse opnd0", 32'(ex_opnd[7:0]), 32'h77);
    chk("loaduse sel0", 32'(ex_fwd_sel[1:0]), 2);

    // r0 never forwards.
    set_instr(1, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    cyc();
    fwd_val = {8'h00, 8'h00, 8'hFF};
    set_instr(1, 0, 3, 2'b01, 'h00, 'h33, 7, 0, 0);
    cyc();
    chk("zero reg opnd", 32'(ex_opnd), 32'h3300);
    chk("zero reg sel", 32'(ex_fwd_sel), 0);

    // Hold freezes EX and the stall counter.
    hold = 1'b1;
    set_instr(1, 1, 2, 2'b11, 'h5C, 'h6D, 2, 1, 0);
    cyc();
    cyc();
    cyc();
    chk("hold ex_valid", 32'(ex_valid), 1);
    chk("hold ex_opnd", 32'(ex_opnd), 32'h3300);
    chk("hold stall_cnt", 32'(stall_cnt), 1);
    hold = 1'b0;

    // Flush during a load-use hazard: bubble, counter unchanged.
    set_instr(1, 0, 0, 2'b00, 0, 0, 2, 1, 1);
    cyc();
    flush = 1'b1;
    set_instr(1, 2, 0, 2'b01, 0, 0, 7, 0, 0);
    cyc();
    flush = 1'b0;
    chk("flush bubble", 32'(ex_valid), 0);
    chk("flush stall_cnt", 32'(stall_cnt), 1);

    // Reset mid-stream, even with hold asserted.
    set_instr(1, 1, 1, 2'b11, 'h21, 'h43, 1, 1, 0);
    cyc();
    rst_n = 1'b0;
    hold  = 1'b1;
    cyc();
    chk("midrst ex_valid", 32'(ex_valid), 0);
    chk("midrst ex_opnd", 32'(ex_opnd), 0);
    chk("midrst ex_fwd_sel", 32'(ex_fwd_sel), 0);
    chk("midrst stall_cnt", 32'(stall_cnt), 0);
    rst_n = 1'b1;
    hold  = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_instr($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7),
                2'($urandom_range(3)), $urandom_range(255), $urandom_range(255),
                $urandom_range(7), $urandom_range(3) != 0, $urandom_range(9) < 3);
      fwd_val = DEPTH * DATA_W'($urandom);
      hold    = $urandom_range(9) == 0;
      flush   = $urandom_range(9) == 0;
      rst_n   = $urandom_range(199) != 0;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
